// File: rtl/fpu_pkg.sv
// Shared rounding-mode encoding and exception flag bit positions for the FPU rounding path.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rm_e;

    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    localparam int FLAG_W = 5;

    // 101/110 are reserved; 111 is only legal as a selector, never as a resolved mode.
    function automatic logic rm_reserved(input logic [2:0] rm);
        return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
    endfunction

endpackage

// File: rtl/fpu_round_core.sv
// Purpose: combinational round-up decision plus increment/overflow/saturation and flag generation.
// Latency: 0 cycles (pure combinational, two independent halves used by different pipe stages).
// Backpressure: none, stateless.
module fpu_round_core
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   dec_sign,
    input  logic                   dec_lsb,
    input  logic                   dec_g,
    input  logic                   dec_r,
    input  logic                   dec_s,
    input  rm_e                    dec_rm,
    output logic                   dec_round_up,

    input  logic                   rnd_sign,
    input  logic [EXP_W-1:0]       rnd_exp,
    input  logic [MAN_W-1:0]       rnd_man,
    input  rm_e                    rnd_rm,
    input  logic                   rnd_round_up,
    input  logic                   rnd_inexact,
    input  logic                   rnd_bad_rm,
    output logic [EXP_W+MAN_W:0]   rnd_data,
    output logic [FLAG_W-1:0]      rnd_flags
);

    localparam int W = EXP_W + MAN_W;

    logic             dec_any;
    logic [W-1:0]     mag;
    logic [W-1:0]     sum;
    logic [EXP_W-1:0] sum_exp;
    logic             special;
    logic             ovf;
    logic             sat_inf;
    logic [W:0]       inf_val;
    logic [W:0]       max_val;

    assign dec_any = dec_g || dec_r || dec_s;

    always_comb begin
        dec_round_up = 1'b0;
        case (dec_rm)
            RNE:     dec_round_up = dec_g && (dec_r || dec_s || dec_lsb);
            RTZ:     dec_round_up = 1'b0;
            RDN:     dec_round_up = dec_any && dec_sign;
            RUP:     dec_round_up = dec_any && !dec_sign;
            RMM:     dec_round_up = dec_g;
            default: dec_round_up = 1'b0;
        endcase
    end

    // Mantissa carry ripples into the exponent naturally through the joint add.
    assign mag     = {rnd_exp, rnd_man};
    assign sum     = mag + {{(W-1){1'b0}}, rnd_round_up};
    assign sum_exp = sum[W-1 -: EXP_W];
    assign special = &rnd_exp;
    assign ovf     = !special && (&sum_exp);

    assign inf_val = {rnd_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign max_val = {rnd_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};

    always_comb begin
        sat_inf = 1'b1;
        case (rnd_rm)
            RNE, RMM: sat_inf = 1'b1;
            RTZ:      sat_inf = 1'b0;
            RDN:      sat_inf = rnd_sign;
            RUP:      sat_inf = !rnd_sign;
            default:  sat_inf = 1'b1;
        endcase
    end

    always_comb begin
        rnd_data = {rnd_sign, sum};
        if (special) begin
            rnd_data = {rnd_sign, mag};
        end else if (ovf) begin
            rnd_data = sat_inf ? inf_val : max_val;
        end
    end

    // A reserved mode still rounds (as RNE) but must not raise any exception.
    always_comb begin
        rnd_flags = '0;
        if (!special && !rnd_bad_rm) begin
            rnd_flags[NX] = rnd_inexact || ovf;
            rnd_flags[UF] = rnd_inexact && (rnd_exp == '0);
            rnd_flags[OF] = ovf;
        end
    end

endmodule

// File: rtl/fpu_round_pipe.sv
// Purpose: two-stage FP rounding pipe with frm register, reserved-mode detection and accrued fflags.
// Latency: 2 cycles from input handshake to out_valid; 1 result/cycle when out_ready stays high.
// Backpressure: S2 stalls on !out_ready, S1 fills behind it, then in_ready drops (combinational from out_ready).
module fpu_round_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [EXP_W+MAN_W+3:0]      in_data,
    input  logic [2:0]                  in_rm,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+MAN_W:0]        out_data,
    output logic [FLAG_W-1:0]           out_flags,
    output logic                        out_bad_rm,
    input  logic                        frm_we,
    input  logic [2:0]                  frm_wdata,
    output logic [2:0]                  frm,
    output logic [FLAG_W-1:0]           fflags,
    input  logic                        fflags_clr
);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic             g;
        logic             r;
        logic             s;
    } in_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        rm_e              rm;
        logic             round_up;
        logic             inexact;
        logic             bad_rm;
    } s1_t;

    in_t                 in_dat;
    logic [2:0]          rm_raw;
    logic                rm_bad;
    rm_e                 rm_eff;
    logic                dec_round_up;
    s1_t                 s1_d;
    s1_t                 s1_q;
    logic                s1_vld;
    logic                s2_adv;
    logic                out_hs;
    logic [EXP_W+MAN_W:0] core_data;
    logic [FLAG_W-1:0]   core_flags;

    assign in_dat = in_t'(in_data);

    // frm is read from the register, so a write in the same cycle only affects later inputs.
    assign rm_raw = (in_rm == DYN) ? frm : in_rm;
    assign rm_bad = rm_reserved(rm_raw);
    assign rm_eff = rm_bad ? RNE : rm_e'(rm_raw);

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s2_adv;
    assign out_hs   = out_valid && out_ready;

    fpu_round_core #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_core (
        .dec_sign     (in_dat.sign),
        .dec_lsb      (in_dat.man[0]),
        .dec_g        (in_dat.g),
        .dec_r        (in_dat.r),
        .dec_s        (in_dat.s),
        .dec_rm       (rm_eff),
        .dec_round_up (dec_round_up),
        .rnd_sign     (s1_q.sign),
        .rnd_exp      (s1_q.exp),
        .rnd_man      (s1_q.man),
        .rnd_rm       (s1_q.rm),
        .rnd_round_up (s1_q.round_up),
        .rnd_inexact  (s1_q.inexact),
        .rnd_bad_rm   (s1_q.bad_rm),
        .rnd_data     (core_data),
        .rnd_flags    (core_flags)
    );

    always_comb begin
        s1_d          = '0;
        s1_d.sign     = in_dat.sign;
        s1_d.exp      = in_dat.exp;
        s1_d.man      = in_dat.man;
        s1_d.rm       = rm_eff;
        s1_d.round_up = dec_round_up;
        s1_d.inexact  = in_dat.g || in_dat.r || in_dat.s;
        s1_d.bad_rm   = rm_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Output payload only reloads on advance, which keeps it frozen during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_flags  <= '0;
            out_bad_rm <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data   <= core_data;
                out_flags  <= core_flags;
                out_bad_rm <= s1_q.bad_rm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm <= 3'b000;
        end else if (frm_we) begin
            frm <= frm_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags <= '0;
        end else if (fflags_clr) begin
            fflags <= out_hs ? out_flags : '0;
        end else if (out_hs) begin
            fflags <= fflags | out_flags;
        end
    end

endmodule

// File: tb/tb_fpu_round_pipe.sv
// Directed-vector bench for fpu_round_pipe with hand-computed IEEE single-precision results.
module tb_fpu_round_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [34:0] in_data;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;
    logic        out_bad_rm;
    logic        frm_we;
    logic [2:0]  frm_wdata;
    logic [2:0]  frm;
    logic [4:0]  fflags;
    logic        fflags_clr;

    int          n_chk;
    int          n_err;
    logic [4:0]  acc;

    fpu_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_flags  (out_flags),
        .out_bad_rm (out_bad_rm),
        .frm_we     (frm_we),
        .frm_wdata  (frm_wdata),
        .frm        (frm),
        .fflags     (fflags),
        .fflags_clr (fflags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] mk(input logic s, input logic [7:0] e,
                                       input logic [22:0] m, input logic [2:0] grs);
        return {s, e, m, grs};
    endfunction

    task automatic set_frm(input logic [2:0] v);
        @(negedge clk);
        frm_we    = 1'b1;
        frm_wdata = v;
        @(posedge clk); #1;
        frm_we = 1'b0;
        check("frm_write", {29'd0, frm}, {29'd0, v});
    endtask

    // One transaction with out_ready high: checks latency, result, flags and accrual.
    task automatic run_one(input string tag, input logic [34:0] d, input logic [2:0] rm,
                           input logic we, input logic [2:0] wd,
                           input logic [31:0] exp_d, input logic [4:0] exp_f, input logic exp_bad);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_rm     = rm;
        frm_we    = we;
        frm_wdata = wd;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        frm_we   = 1'b0;
        check({tag, "_vld_n1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld_n2"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_flags"}, {27'd0, out_flags}, {27'd0, exp_f});
        check({tag, "_bad_rm"}, {31'd0, out_bad_rm}, {31'd0, exp_bad});
        @(posedge clk); #1;
        acc = acc | exp_f;
        check({tag, "_fflags"}, {27'd0, fflags}, {27'd0, acc});
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [34:0] bp_vec [4];
    int          n_acc;
    int          n_late;
    logic        rdy_s;

    initial begin
        n_chk = 0; n_err = 0; acc = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rm = 3'b000;
        out_ready = 1'b1; frm_we = 1'b0; frm_wdata = 3'b000; fflags_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", {27'd0, out_flags}, 32'd0);
        check("rst_bad_rm", {31'd0, out_bad_rm}, 32'd0);
        check("rst_frm", {29'd0, frm}, 32'd0);
        check("rst_fflags", {27'd0, fflags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_one("rne_tie_lsb1", mk(0, 8'h7F, 23'h000001, 3'b100), 3'b000, 0, 0, 32'h3F800002, 5'b00001, 0);
        run_one("rne_tie_lsb0", mk(0, 8'h7F, 23'h000002, 3'b100), 3'b000, 0, 0, 32'h3F800002, 5'b00001, 0);
        run_one("ovf_rne", mk(0, 8'hFE, 23'h7FFFFF, 3'b100), 3'b000, 0, 0, 32'h7F800000, 5'b00101, 0);
        run_one("ovf_rtz", mk(0, 8'hFE, 23'h7FFFFF, 3'b100), 3'b001, 0, 0, 32'h7F7FFFFF, 5'b00001, 0);
        run_one("neg_rup", mk(1, 8'hFE, 23'h7FFFFF, 3'b100), 3'b011, 0, 0, 32'hFF7FFFFF, 5'b00001, 0);
        run_one("ovf_rdn_neg", mk(1, 8'hFE, 23'h7FFFFF, 3'b100), 3'b010, 0, 0, 32'hFF800000, 5'b00101, 0);
        run_one("nan_pass", mk(0, 8'hFF, 23'h400000, 3'b111), 3'b000, 0, 0, 32'h7FC00000, 5'b00000, 0);
        run_one("underflow", mk(0, 8'h00, 23'h000001, 3'b010), 3'b000, 0, 0, 32'h00000001, 5'b00011, 0);
        run_one("rmm_tie", mk(0, 8'h7F, 23'h000000, 3'b100), 3'b100, 0, 0, 32'h3F800001, 5'b00001, 0);
        run_one("man_carry", mk(0, 8'h7F, 23'h7FFFFF, 3'b110), 3'b000, 0, 0, 32'h40000000, 5'b00001, 0);
        run_one("rsvd_rm", mk(0, 8'h7F, 23'h000001, 3'b100), 3'b101, 0, 0, 32'h3F800002, 5'b00000, 1);

        set_frm(3'b011);
        run_one("dyn_rup_neg", mk(1, 8'h80, 23'h000010, 3'b011), 3'b111, 0, 0, 32'hC0000010, 5'b00001, 0);
        run_one("dyn_old_frm", mk(0, 8'h7F, 23'h000000, 3'b100), 3'b111, 1, 3'b001, 32'h3F800001, 5'b00001, 0);
        check("dyn_new_frm", {29'd0, frm}, 32'd1);
        set_frm(3'b110);
        run_one("dyn_rsvd_frm", mk(0, 8'h7F, 23'h000001, 3'b100), 3'b111, 0, 0, 32'h3F800002, 5'b00000, 1);
        set_frm(3'b000);

        // Backpressure: four offered while stalled, only two fit.
        @(negedge clk);
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        acc = '0;
        check("bp_clr", {27'd0, fflags}, 32'd0);
        bp_vec[0] = mk(0, 8'hFE, 23'h7FFFFF, 3'b100);
        bp_vec[1] = mk(0, 8'h00, 23'h000001, 3'b010);
        bp_vec[2] = mk(0, 8'h7F, 23'h000001, 3'b100);
        bp_vec[3] = mk(0, 8'h7F, 23'h000002, 3'b100);
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_rm    = 3'b000;
            in_data  = bp_vec[n_acc];
            rdy_s    = in_ready;
            @(posedge clk);
            if (rdy_s) n_acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", n_acc, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_a", out_data, 32'h7F800000);
        check("bp_no_accrue", {27'd0, fflags}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_stable_a", out_data, 32'h7F800000);
        check("bp_stable_fa", {27'd0, out_flags}, 32'h05);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_fflags_a", {27'd0, fflags}, 32'h05);
        check("bp_valid_b", {31'd0, out_valid}, 32'd1);
        check("bp_data_b", out_data, 32'h00000001);
        check("bp_flags_b", {27'd0, out_flags}, 32'h03);
        @(posedge clk); #1;
        check("bp_fflags_b", {27'd0, fflags}, 32'h07);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Clear coinciding with an NX-only handshake.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = mk(0, 8'h7F, 23'h000001, 3'b100);
        in_rm    = 3'b000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        check("clr_hs_fflags", {27'd0, fflags}, 32'h01);

        // Reset with two transactions in flight.
        set_frm(3'b011);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = mk(0, 8'h7F, 23'h000001, 3'b100);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_fflags", {27'd0, fflags}, 32'd0);
        check("mid_rst_frm", {29'd0, frm}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n_late    = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) n_late++;
        end
        check("mid_rst_no_late", n_late, 32'd0);
        check("mid_rst_fflags_after", {27'd0, fflags}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
